// File: rtl/stack_pkg.sv
// Shared constants and helpers for the LIFO stack unit.
// Holds default geometry and the derived pointer-width function.
package stack_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   // Pointer must hold 0..DEPTH inclusive, hence one extra bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stack_if.sv
// Command/status bundle between a stack user and stack_unit.
// master: drives push/pop/tos/clr_err/din; slave: drives dout/count/flags.
interface stack_if
   import stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);

   localparam int PW = ptr_w(DEPTH);

   logic             push;
   logic             pop;
   logic             tos;
   logic             clr_err;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic [PW-1:0]    count;
   logic             empty;
   logic             full;
   logic             ovf;
   logic             unf;
   logic             cmd_err;

   modport master (
      output push, pop, tos, clr_err, din,
      input  dout, count, empty, full, ovf, unf, cmd_err
   );

   modport slave (
      input  push, pop, tos, clr_err, din,
      output dout, count, empty, full, ovf, unf, cmd_err
   );

endinterface

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register array: one sync write port, one async read port.
// Ports: clk, we_i, waddr_i, wdata_i, raddr_i, rdata_o. Contents not reset.
module stack_mem
   import stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack: pointer, registered read data, sticky error flags, decode.
// Ports: clk, rst (async, active-high), bus (stack_if.slave).
module stack_unit
   import stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic  clk,
   input  logic  rst,
   stack_if.slave bus
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = $clog2(DEPTH);
   localparam logic [PW-1:0] ONE  = PW'(1);
   localparam logic [PW-1:0] MAXP = PW'(DEPTH);

   logic [PW-1:0]    sp_q, sp_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             cmd_q, cmd_d;
   logic             we;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             is_empty, is_full;
   logic             multi, do_push, do_pop, do_tos;

   assign is_empty = (sp_q == '0);
   assign is_full  = (sp_q == MAXP);

   // Decode into mutually exclusive terms so the case below is one-hot.
   assign multi   = (bus.push & bus.pop) | (bus.push & bus.tos)
                  | (bus.pop & bus.tos);
   assign do_push = bus.push & ~bus.pop & ~bus.tos;
   assign do_pop  = bus.pop & ~bus.push & ~bus.tos;
   assign do_tos  = bus.tos & ~bus.push & ~bus.pop;

   // Top entry lives at sp-1; value at sp==0 is never consumed.
   assign rd_addr = sp_q[AW-1:0] - AW'(1);

   stack_mem #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_mem (
      .clk    (clk),
      .we_i   (we),
      .waddr_i(sp_q[AW-1:0]),
      .wdata_i(bus.din),
      .raddr_i(rd_addr),
      .rdata_o(rd_data)
   );

   always_comb begin
      sp_d   = sp_q;
      dout_d = dout_q;
      we     = 1'b0;
      // Clear first; an error in the same cycle overrides below.
      ovf_d  = bus.clr_err ? 1'b0 : ovf_q;
      unf_d  = bus.clr_err ? 1'b0 : unf_q;
      cmd_d  = bus.clr_err ? 1'b0 : cmd_q;
      unique case (1'b1)
         multi: cmd_d = 1'b1;
         do_push: begin
            if (is_full) begin
               ovf_d = 1'b1;
            end else begin
               we   = 1'b1;
               sp_d = sp_q + ONE;
            end
         end
         do_pop: begin
            if (is_empty) begin
               unf_d = 1'b1;
            end else begin
               dout_d = rd_data;
               sp_d   = sp_q - ONE;
            end
         end
         do_tos: begin
            if (is_empty) unf_d = 1'b1;
            else          dout_d = rd_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q   <= '0;
         dout_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         cmd_q  <= 1'b0;
      end else begin
         sp_q   <= sp_d;
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
         cmd_q  <= cmd_d;
      end
   end

   assign bus.dout    = dout_q;
   assign bus.count   = sp_q;
   assign bus.empty   = is_empty;
   assign bus.full    = is_full;
   assign bus.ovf     = ovf_q;
   assign bus.unf     = unf_q;
   assign bus.cmd_err = cmd_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: directed cases plus random traffic
// checked against a queue-based LIFO reference model.
module tb_stack_unit;

   localparam int W = 8;
   localparam int D = 16;

   typedef struct packed {
      logic [W-1:0] dout;
      logic [4:0]   count;
      logic         empty;
      logic         full;
      logic         ovf;
      logic         unf;
      logic         cmd_err;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

   stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   obs_t  eq [$];
   string tq [$];

   int           stk [$];
   logic [W-1:0] m_dout = '0;
   bit           m_ovf, m_unf, m_cmd;

   function automatic obs_t sample();
      obs_t o;
      o.dout    = bus.dout;
      o.count   = bus.count;
      o.empty   = bus.empty;
      o.full    = bus.full;
      o.ovf     = bus.ovf;
      o.unf     = bus.unf;
      o.cmd_err = bus.cmd_err;
      return o;
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.dout    = m_dout;
      o.count   = 5'(stk.size());
      o.empty   = (stk.size() == 0);
      o.full    = (stk.size() == D);
      o.ovf     = m_ovf;
      o.unf     = m_unf;
      o.cmd_err = m_cmd;
      return o;
   endfunction

   task automatic check(input string nm, input obs_t a, input obs_t e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got dout=%h cnt=%0d e=%b f=%b o=%b u=%b c=%b, want dout=%h cnt=%0d e=%b f=%b o=%b u=%b c=%b",
                  nm, a.dout, a.count, a.empty, a.full, a.ovf, a.unf, a.cmd_err,
                  e.dout, e.count, e.empty, e.full, e.ovf, e.unf, e.cmd_err);
      end
   endtask

   // Monitor: one expectation per issued cycle, compared after the edge.
   always @(posedge clk) begin
      #1;
      if (eq.size() > 0) check(tq.pop_front(), sample(), eq.pop_front());
   end

   task automatic model(input bit pu, po, tp, cl, input logic [W-1:0] d);
      if (cl) begin
         m_ovf = 0; m_unf = 0; m_cmd = 0;
      end
      if (int'(pu) + int'(po) + int'(tp) > 1) m_cmd = 1;
      else if (pu) begin
         if (stk.size() == D) m_ovf = 1;
         else stk.push_back(int'(d));
      end else if (po) begin
         if (stk.size() == 0) m_unf = 1;
         else m_dout = W'(stk.pop_back());
      end else if (tp) begin
         if (stk.size() == 0) m_unf = 1;
         else m_dout = W'(stk[$]);
      end
   endtask

   task automatic step(input bit pu, po, tp, cl,
                       input logic [W-1:0] d, input string nm);
      @(negedge clk);
      bus.push = pu; bus.pop = po; bus.tos = tp;
      bus.clr_err = cl; bus.din = d;
      model(pu, po, tp, cl, d);
      eq.push_back(model_obs());
      tq.push_back(nm);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, '0, "idle");
   endtask

   task automatic drain();
      @(posedge clk);
      #3;
      if (eq.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain: %0d expectations left, want 0", eq.size());
         eq.delete(); tq.delete();
      end
   endtask

   task automatic model_reset();
      stk.delete();
      m_dout = '0; m_ovf = 0; m_unf = 0; m_cmd = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      bit cl;
      bus.push = 0; bus.pop = 0; bus.tos = 0;
      bus.clr_err = 0; bus.din = '0;
      model_reset();
      #3;
      check("reset", sample(), model_obs());
      @(negedge clk);
      rst = 0;

      step(1, 0, 0, 0, 8'h11, "push11");
      step(1, 0, 0, 0, 8'h22, "push22");
      step(1, 0, 0, 0, 8'h33, "push33");
      step(0, 1, 0, 0, '0, "pop33");
      step(0, 0, 1, 0, '0, "tos22");
      step(0, 1, 0, 0, '0, "pop22");
      step(0, 1, 0, 0, '0, "pop11");

      for (int i = 0; i < D; i++) step(1, 0, 0, 0, W'(i), "fill");
      step(1, 0, 0, 0, 8'hFF, "push_full");
      for (int i = 0; i < D; i++) step(0, 1, 0, 0, '0, "drain_pop");

      step(0, 1, 0, 0, '0, "pop_empty");
      step(0, 0, 0, 1, '0, "clr_err");
      step(0, 0, 1, 0, '0, "tos_empty");
      step(0, 1, 0, 1, '0, "clr_vs_unf");
      step(0, 0, 0, 1, '0, "clr_err2");

      step(1, 0, 0, 0, 8'h5A, "push5A");
      step(1, 0, 0, 0, 8'hC3, "pushC3");
      step(1, 1, 0, 0, 8'h77, "push_pop");
      step(0, 0, 1, 0, '0, "tos_after_multi");
      step(0, 1, 1, 0, '0, "pop_tos");
      step(0, 0, 0, 1, '0, "clr_err3");
      step(0, 1, 0, 0, '0, "popC3");
      step(0, 1, 0, 0, '0, "pop5A");

      step(1, 0, 0, 0, 8'hAA, "pushAA");
      step(0, 1, 0, 0, '0, "popAA");
      idle();
      drain();

      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, W'(8'h40 + i), "pre_rst");
      step(0, 0, 1, 0, '0, "pre_rst_tos");
      idle();
      drain();
      rst = 1;
      #1;
      model_reset();
      check("async_rst", sample(), model_obs());
      @(negedge clk);
      rst = 0;
      step(0, 0, 1, 0, '0, "tos_after_rst");
      step(0, 0, 0, 1, '0, "clr_after_rst");

      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 250; i++) begin
            r  = int'($urandom_range(0, 15));
            cl = ($urandom_range(0, 15) == 0);
            if (r < 8) begin
               if (ph == 0) step(1, 0, 0, cl, W'($urandom), "rnd_push");
               else         step(0, 1, 0, cl, '0, "rnd_pop");
            end else if (r < 10) begin
               if (ph == 0) step(0, 1, 0, cl, '0, "rnd_pop");
               else         step(1, 0, 0, cl, W'($urandom), "rnd_push");
            end else if (r < 12) step(0, 0, 1, cl, '0, "rnd_tos");
            else if (r < 14)     step(0, 0, 0, cl, '0, "rnd_idle");
            else if (r == 14)    step(1, 0, 1, cl, W'($urandom), "rnd_multi");
            else                 step(0, 1, 1, cl, '0, "rnd_multi2");
         end
      end
      idle();
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of stack entries; power of two, minimum 2.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 push  input  1  push din onto stack this cycle.
REQ-006 pop  input  1  remove top entry and present it on dout.
REQ-007 tos  input  1  present top entry on dout without removing it.
REQ-008 clr_err  input  1  synchronous clear of sticky error flags.
REQ-009 din  input  WIDTH  data to push.
REQ-010 dout  output  WIDTH  registered read data from the last pop/tos.
REQ-011 count  output  $clog2(DEPTH)+1  current number of valid entries.
REQ-012 empty  output  1  high when count==0 (combinational from count).
REQ-013 full  output  1  high when count==DEPTH (combinational from count).
REQ-014 ovf  output  1  sticky: a push was attempted while full.
REQ-015 unf  output  1  sticky: a pop or tos was attempted while empty.
REQ-016 cmd_err  output  1  sticky: more than one of push/pop/tos asserted in one cycle.

Function
REQ-017 Stack pointer sp (= count) indexes the next free entry; top entry is mem[sp-1].
REQ-018 Legal push (only push high, not full): mem[sp] <= din, sp <= sp+1; dout unchanged.
REQ-019 Legal pop (only pop high, not empty): dout <= mem[sp-1], sp <= sp-1; dout valid in the cycle after the pop edge (latency 1).
REQ-020 Legal tos (only tos high, not empty): dout <= mem[sp-1], sp unchanged; latency 1.
REQ-021 Push when full: no write, sp unchanged, dout unchanged, ovf <= 1.
REQ-022 Pop or tos when empty: sp unchanged, dout unchanged, unf <= 1.
REQ-023 Two or more of push/pop/tos high in one cycle: no state change except cmd_err <= 1.
REQ-024 No command high: all state holds.
REQ-025 clr_err high clears ovf, unf and cmd_err on the next edge; a same-cycle error event takes priority and sets its flag.
REQ-026 A pushed value is readable by pop/tos in the immediately following cycle (no bubble).
REQ-027 sp never wraps: it stays within 0..DEPTH under all stimulus.

Reset
REQ-028 On rst high: sp=0, dout=0, ovf=0, unf=0, cmd_err=0, immediately and independent of clk.
REQ-029 Storage array contents are not reset; contents are unobservable until written because sp=0.
REQ-030 rst asserted mid-sequence discards all entries; first command after release behaves as on an empty stack.

Structure
REQ-031 Shared package stack_pkg holds default WIDTH/DEPTH constants and the derived pointer-width function; controller and datapath import it.
REQ-032 One sub-module stack_mem: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port addressed by sp-1.
REQ-033 stack_unit holds sp, dout register, error flags and command decode; no other sub-modules.

Verification
REQ-034 Reset, then push 0x11, 0x22, 0x33 -> count=3; pop -> dout=0x33, count=2; tos -> dout=0x22, count=2.
REQ-035 Push 16 values 0x00..0x0F -> full=1, count=16; 17th push 0xFF -> ovf=1, count=16; 16 pops -> dout sequence 0x0F..0x00, empty=1.
REQ-036 Pop on empty stack -> unf=1, dout unchanged, count=0; clr_err pulse -> unf=0 next cycle.
REQ-037 push and pop high together with count=2 -> cmd_err=1, count=2, top unchanged; tos -> dout equals prior top.
REQ-038 Push 0xAA, next cycle pop -> dout=0xAA one cycle later, empty=1.
REQ-039 After 5 pushes assert rst asynchronously between edges -> count=0, dout=0, flags=0 immediately; tos afterwards -> unf=1.
